// File: rtl/frame_loader.sv
// frame_loader
//   Byte-stream to Wishbone frame writer. Hunts for a SYNC byte, buffers the
//   32 data bytes that follow, and compares the next byte against the running
//   XOR of the data. A matching frame is written as an 8-word pipelined
//   Wishbone burst to word addresses 0..7. Bad or stalled frames are dropped
//   whole, so the slave sees either a complete frame or nothing.
//
//   State table
//     state    | meaning
//     ST_HUNT  | discarding bytes until SYNC_BYTE
//     ST_DATA  | storing the 32 data bytes, accumulating the XOR checksum
//     ST_CHECK | waiting for the checksum byte
//     ST_WRITE | Wishbone burst in flight, byte input held off
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   i_byte, i_byte_valid         byte stream in
//   o_byte_ready                 byte accepted when valid && ready
//   o_frame_ok / o_frame_err     1-clk result pulses
//   o_busy                       high outside ST_HUNT
//   o_wb_*, i_wb_*               pipelined Wishbone write master
module frame_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter int         TIMEOUT_W      = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic        o_frame_ok,
  output logic        o_frame_err,
  output logic        o_busy,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [2:0]  o_wb_addr,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_wdata,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_rdata
);

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [4:0]           idx_q, idx_d;
  logic [7:0]           csum_q, csum_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [3:0]           iss_q, iss_d;
  logic [3:0]           ack_q, ack_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 ok_q, ok_d;
  logic                 err_q, err_d;
  logic [7:0][31:0]     buf_q, buf_d;

  logic accept;
  logic unused_rdata;

  assign unused_rdata = ^i_wb_rdata;

  assign o_byte_ready = (state_q != ST_WRITE);
  assign accept       = i_byte_valid && o_byte_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    tmo_d   = tmo_q;
    iss_d   = iss_q;
    ack_d   = ack_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    buf_d   = buf_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_HUNT: begin
        tmo_d = '0;
        if (accept && (i_byte == SYNC_BYTE)) begin
          state_d = ST_DATA;
          idx_d   = '0;
          csum_d  = '0;
        end
      end

      ST_DATA: begin
        if (accept) begin
          // byte k lands in word k/4, lane k%4 (first byte is LSB of word 0)
          buf_d[idx_q[4:2]][{idx_q[1:0], 3'b000} +: 8] = i_byte;
          csum_d = csum_q ^ i_byte;
          idx_d  = idx_q + 5'd1;
          tmo_d  = '0;
          if (idx_q == 5'd31) state_d = ST_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_HUNT;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_CHECK: begin
        if (accept) begin
          tmo_d = '0;
          if (i_byte == csum_q) begin
            state_d = ST_WRITE;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            iss_d   = '0;
            ack_d   = '0;
          end else begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_HUNT;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_WRITE: begin
        if (stb_q && !i_wb_stall) begin
          iss_d = iss_q + 4'd1;
          if (iss_q == 4'd7) stb_d = 1'b0;
        end
        // acks may arrive in the same cycle as an issue; count them regardless
        if (i_wb_ack) begin
          ack_d = ack_q + 4'd1;
          if (ack_q == 4'd7) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            ok_d    = 1'b1;
            state_d = ST_HUNT;
          end
        end
      end

      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_HUNT;
      idx_q   <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      iss_q   <= '0;
      ack_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      iss_q   <= iss_d;
      ack_q   <= ack_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  // frame buffer is pure datapath; only written while in ST_DATA
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_busy      = (state_q != ST_HUNT);
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = cyc_q;
  assign o_wb_sel    = cyc_q ? 4'hF : 4'h0;
  assign o_wb_addr   = stb_q ? iss_q[2:0] : 3'd0;
  assign o_wb_wdata  = stb_q ? buf_q[iss_q[2:0]] : 32'd0;

endmodule
